div_unit: RTL

//  Out-of-pipeline serial integer divider for RV32M DIV/DIVU/REM/REMU. Accepts one op from the

---
 rtl/div_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Serial radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, single op in flight, one-cycle done pulse.
module div_unit #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FAST_SPECIAL   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      div_valid,
  input  logic [1:0]                div_control,
  input  logic [REG_ADDR_WIDTH-1:0] div_rd,
  input  logic [XLEN-1:0]           div_rs1,
  input  logic [XLEN-1:0]           div_rs2,
  output logic                      div_busy,
  output logic                      div_done,
  output logic                      wb_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]           wb_wr_data
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [XLEN-1:0]           r_rem;
  logic [XLEN-1:0]           r_quo;
  logic [XLEN-1:0]           r_div;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [1:0]                r_op;
  logic                      r_neg_q;
  logic                      r_neg_r;

  logic            w_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_q_res;
  logic [XLEN-1:0] w_r_res;
  logic [XLEN-1:0] w_res;

  // control bit 0 selects unsigned, bit 1 selects remainder
  assign w_sgn   = ~div_control[0];
  assign w_a_neg = w_sgn & div_rs1[XLEN-1];
  assign w_b_neg = w_sgn & div_rs2[XLEN-1];
  assign w_a_abs = w_a_neg ? -div_rs1 : div_rs1;
  assign w_b_abs = w_b_neg ? -div_rs2 : div_rs2;
  assign w_zero  = (div_rs2 == '0);
  assign w_ovf   = w_sgn
                 & (div_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                 & (div_rs2 == '1);
  assign w_fast  = FAST_SPECIAL & (w_zero | w_ovf);

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};

  assign w_q_res = r_neg_q ? -r_quo : r_quo;
  assign w_r_res = r_neg_r ? -r_rem : r_rem;
  assign w_res   = r_op[1] ? w_r_res : w_q_res;

  // outputs decode registered state only; x0 writes carry zero data
  assign div_busy   = (r_state != S_IDLE);
  assign div_done   = (r_state == S_DONE);
  assign wb_wr_en   = div_done;
  assign wb_rd      = div_done ? r_rd : '0;
  assign wb_wr_data = (div_done && (r_rd != '0)) ? w_res : '0;

  // divider FSM: accept, iterate one bit per cycle, present result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_rd    <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (div_valid && !flush) begin
            r_rd  <= div_rd;
            r_op  <= div_control;
            r_cnt <= CW'(XLEN-1);
            if (w_fast) begin
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_quo   <= w_zero ? '1 : div_rs1;
              r_rem   <= w_zero ? div_rs1 : '0;
              r_state <= S_DONE;
            end else begin
              r_neg_q <= (w_a_neg ^ w_b_neg) & ~w_zero;
              r_neg_r <= w_a_neg;
              r_quo   <= w_a_abs;
              r_rem   <= '0;
              r_div   <= w_b_abs;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_trial[XLEN] ? w_rem_sh[XLEN-1:0]
                                   : w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
